// File: rtl/video_pkg.sv
// Shared types and default sizing for the video line fetch path.
package video_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StAck
  } fetch_state_e;

  localparam int unsigned DefWordsPerLine = 320;
  localparam int unsigned DefBurstLen     = 4;
  localparam int unsigned DefFifoDepth    = 16;

endpackage

// File: rtl/sync_fifo.sv
// 16-bit first-word fall-through FIFO with synchronous flush and occupancy count.
module sync_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [15:0]              wdata_i,
  input  logic                     pop_i,
  output logic [15:0]              rdata_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [15:0]      mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i & (count_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push_i & ((count_q != Full) | do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/video_line_fetcher.sv
// Fetches scanline words from SDRAM in fixed bursts into a line FIFO for the pixel pipeline.
module video_line_fetcher
  import video_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = DefWordsPerLine,
  parameter int unsigned BURST_LEN      = DefBurstLen,
  parameter int unsigned FIFO_DEPTH     = DefFifoDepth
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [23:0] fb_base_x16,
  input  logic        frame_start_i,
  input  logic        line_start_i,
  input  logic        pix_rd_i,
  output logic [15:0] pix_data_o,
  output logic        pix_valid_o,
  output logic        underflow_o,
  output logic        late_o,
  output logic        video_sdram_rd,
  output logic [23:0] video_sdram_addr_x16,
  input  logic        video_sdram_rdy,
  input  logic [15:0] video_sdram_rdata,
  output logic        video_sdram_ack
);

  localparam int unsigned WlW  = $clog2(WORDS_PER_LINE + 1);
  localparam int unsigned BcW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [WlW-1:0]  WordsLine = WlW'(WORDS_PER_LINE);
  localparam logic [WlW-1:0]  BurstWl   = WlW'(BURST_LEN);
  localparam logic [BcW-1:0]  LastBeat  = BcW'(BURST_LEN - 1);
  localparam logic [CntW-1:0] MaxFill   = CntW'(FIFO_DEPTH - BURST_LEN);
  localparam logic [23:0]     BurstAddr = 24'(BURST_LEN);

  fetch_state_e   state_q, state_d;
  logic [23:0]    cur_addr_q, cur_addr_d;
  logic [23:0]    fb_base_q;
  logic [WlW-1:0] words_left_q, words_left_d;
  logic [BcW-1:0] beat_cnt_q, beat_cnt_d;
  logic           restart_pending_q, restart_pending_d;
  logic           line_pending_q, line_pending_d;
  logic           underflow_q, underflow_d;
  logic           late_q, late_d;
  logic           flush, fifo_push;
  logic [CntW-1:0] fifo_count;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush),
    .push_i  (fifo_push),
    .wdata_i (video_sdram_rdata),
    .pop_i   (pix_rd_i),
    .rdata_o (pix_data_o),
    .valid_o (pix_valid_o),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d         = state_q;
    beat_cnt_d      = beat_cnt_q;
    cur_addr_d      = cur_addr_q;
    video_sdram_rd  = 1'b0;
    video_sdram_ack = 1'b0;
    fifo_push       = 1'b0;
    flush           = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (restart_pending_q) begin
          flush      = 1'b1;
          cur_addr_d = fb_base_q;
        end else if (!frame_start_i && words_left_q != '0 && fifo_count <= MaxFill) begin
          state_d    = StReq;
          beat_cnt_d = '0;
        end
      end
      StReq: begin
        video_sdram_rd = 1'b1;
        if (video_sdram_rdy) begin
          fifo_push  = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LastBeat) state_d = StAck;
        end
      end
      StAck: begin
        video_sdram_ack = 1'b1;
        cur_addr_d      = cur_addr_q + BurstAddr;
        state_d         = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A line start seen while a restart is outstanding is deferred until the flush.
  always_comb begin
    words_left_d      = words_left_q;
    line_pending_d    = line_pending_q;
    late_d            = late_q;
    restart_pending_d = frame_start_i | (restart_pending_q & ~flush);
    underflow_d       = underflow_q | (pix_rd_i & ~pix_valid_o);
    if (state_q == StAck) words_left_d = words_left_q - BurstWl;
    if (flush) begin
      words_left_d   = line_pending_q ? WordsLine : '0;
      line_pending_d = 1'b0;
    end
    if (line_start_i) begin
      if (frame_start_i || (restart_pending_q && !flush)) begin
        line_pending_d = 1'b1;
      end else if (flush || words_left_q == '0) begin
        words_left_d = WordsLine;
      end else begin
        late_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q           <= StIdle;
      cur_addr_q        <= '0;
      fb_base_q         <= '0;
      words_left_q      <= '0;
      beat_cnt_q        <= '0;
      restart_pending_q <= 1'b0;
      line_pending_q    <= 1'b0;
      underflow_q       <= 1'b0;
      late_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      cur_addr_q        <= cur_addr_d;
      words_left_q      <= words_left_d;
      beat_cnt_q        <= beat_cnt_d;
      restart_pending_q <= restart_pending_d;
      line_pending_q    <= line_pending_d;
      underflow_q       <= underflow_d;
      late_q            <= late_d;
      if (frame_start_i) fb_base_q <= fb_base_x16;
    end
  end

  assign video_sdram_addr_x16 = cur_addr_q;
  assign underflow_o          = underflow_q;
  assign late_o               = late_q;

endmodule

// File: tb/tb_video_line_fetcher.sv
// Directed bench for video_line_fetcher with a simple burst-responding SDRAM model.
module tb_video_line_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] fb_base;
  logic        frame_start, line_start, pix_rd;
  logic [15:0] pix_data;
  logic        pix_valid, underflow, late;
  logic        sd_rd, sd_ack, sd_rdy;
  logic [23:0] sd_addr;
  logic [15:0] sd_rdata;

  int checks = 0;
  int errors = 0;

  logic [23:0] req_q[$];
  int ack_cnt = 0;
  int rdy_total = 0;
  int sd_wait = 0;
  int sd_beats = 0;
  bit sd_active = 0;

  always #5 clk = ~clk;

  video_line_fetcher dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .fb_base_x16          (fb_base),
    .frame_start_i        (frame_start),
    .line_start_i         (line_start),
    .pix_rd_i             (pix_rd),
    .pix_data_o           (pix_data),
    .pix_valid_o          (pix_valid),
    .underflow_o          (underflow),
    .late_o               (late),
    .video_sdram_rd       (sd_rd),
    .video_sdram_addr_x16 (sd_addr),
    .video_sdram_rdy      (sd_rdy),
    .video_sdram_rdata    (sd_rdata),
    .video_sdram_ack      (sd_ack)
  );

  function automatic logic [15:0] mem_word(input logic [23:0] a);
    return a[15:0] ^ 16'hC3C3;
  endfunction

  // SDRAM model: two wait cycles, then four data beats; logs each request address.
  always @(negedge clk) begin
    if (sd_ack) ack_cnt++;
    if (rst) begin
      sd_rdy = 1'b0; sd_wait = 0; sd_beats = 0; sd_active = 0;
    end else if (sd_rd && sd_beats < 4) begin
      if (!sd_active) begin
        sd_active = 1;
        req_q.push_back(sd_addr);
      end
      if (sd_wait < 2) begin
        sd_rdy = 1'b0;
        sd_wait++;
      end else begin
        sd_rdy   = 1'b1;
        sd_rdata = mem_word(sd_addr + 24'(sd_beats));
        sd_beats++;
        rdy_total++;
      end
    end else begin
      sd_rdy = 1'b0;
      if (!sd_rd) begin
        sd_active = 0; sd_wait = 0; sd_beats = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_line();
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  // Pop every available word, checking data against base+k, until `words` consumed.
  task automatic consume(input string tag, input logic [23:0] base, input int first,
                         input int words);
    int k = first;
    for (int c = 0; c < 6000 && k < words; c++) begin
      @(negedge clk);
      pix_rd = 1'b0;
      if (pix_valid) begin
        check(tag, pix_data, mem_word(base + 24'(k)));
        pix_rd = 1'b1;
        k++;
      end
    end
    @(negedge clk);
    pix_rd = 1'b0;
    check({tag, "_count"}, k, words);
  endtask

  task automatic pop_one(input string tag, input logic [15:0] exp);
    check({tag, "_valid"}, pix_valid, 1'b1);
    check(tag, pix_data, exp);
    pix_rd = 1'b1;
    @(negedge clk);
    pix_rd = 1'b0;
  endtask

  initial begin
    int base_i, ack_base, rdy_base;
    bit hit;
    rst = 1'b1; fb_base = '0; frame_start = 1'b0; line_start = 1'b0; pix_rd = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rd", sd_rd, 1'b0);
    check("rst_ack", sd_ack, 1'b0);
    check("rst_addr", sd_addr, 24'h0);
    check("rst_valid", pix_valid, 1'b0);
    check("rst_underflow", underflow, 1'b0);
    check("rst_late", late, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_req", sd_rd, 1'b0);

    // Full line from 0x001000, frame and line start in the same cycle
    base_i = req_q.size(); ack_base = ack_cnt;
    fb_base = 24'h001000; frame_start = 1'b1; line_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0; line_start = 1'b0;
    consume("line1_data", 24'h001000, 0, 320);
    repeat (10) @(negedge clk);
    check("line1_bursts", req_q.size() - base_i, 80);
    for (int i = 0; i < 80 && base_i + i < req_q.size(); i++)
      check("line1_addr", req_q[base_i + i], 24'h001000 + 24'(4 * i));
    check("line1_last_addr", req_q[req_q.size() - 1], 24'h00113C);
    check("line1_acks", ack_cnt - ack_base, 80);
    check("line1_idle", sd_rd, 1'b0);
    check("line1_no_underflow", underflow, 1'b0);
    check("line1_no_late", late, 1'b0);

    // Stalled consumer: fill to depth, then resume after four pops
    base_i = req_q.size();
    pulse_line();
    repeat (200) @(negedge clk);
    check("stall_bursts", req_q.size() - base_i, 4);
    check("stall_rd", sd_rd, 1'b0);
    check("stall_late", late, 1'b0);
    for (int i = 0; i < 3; i++) pop_one("stall_pop", mem_word(24'h001140 + 24'(i)));
    repeat (30) @(negedge clk);
    check("stall_3pops_no_req", req_q.size() - base_i, 4);
    pop_one("stall_pop4", mem_word(24'h001143));
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (req_q.size() - base_i == 5) hit = 1;
    end
    check("resume_req", hit, 1'b1);
    check("resume_addr", sd_addr, 24'h001150);
    pulse_line();
    check("late_set", late, 1'b1);
    consume("line2_data", 24'h001140, 4, 320);
    repeat (20) @(negedge clk);
    check("line2_bursts_unchanged", req_q.size() - base_i, 80);
    check("line2_idle", sd_rd, 1'b0);

    // Underflow is sticky
    pix_rd = 1'b1;
    @(negedge clk);
    pix_rd = 1'b0;
    check("underflow_set", underflow, 1'b1);
    repeat (3) @(negedge clk);
    check("underflow_sticky", underflow, 1'b1);

    // Frame start on the second beat of a burst
    base_i = req_q.size(); ack_base = ack_cnt; rdy_base = rdy_total;
    pulse_line();
    hit = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clk);
      #1;
      if (sd_beats == 2) hit = 1;
    end
    check("beat2_seen", hit, 1'b1);
    fb_base = 24'h002000; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_addr", req_q[base_i], 24'h001280);
    check("abort_bursts", req_q.size() - base_i, 1);
    check("abort_beats", rdy_total - rdy_base, 4);
    check("abort_acks", ack_cnt - ack_base, 1);
    check("flush_empty", pix_valid, 1'b0);
    check("flush_no_req", sd_rd, 1'b0);
    check("frame_keeps_underflow", underflow, 1'b1);
    check("frame_keeps_late", late, 1'b1);
    pulse_line();
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (sd_rd) hit = 1;
    end
    check("newbase_req", hit, 1'b1);
    check("newbase_addr", sd_addr, 24'h002000);

    // Asynchronous reset mid-request
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rd", sd_rd, 1'b0);
    check("async_ack", sd_ack, 1'b0);
    check("async_addr", sd_addr, 24'h0);
    check("async_valid", pix_valid, 1'b0);
    check("async_underflow", underflow, 1'b0);
    check("async_late", late, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Address wrap at the top of the 24-bit space
    base_i = req_q.size();
    fb_base = 24'hFFFFFC; frame_start = 1'b1; line_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0; line_start = 1'b0;
    consume("wrap_data", 24'hFFFFFC, 0, 8);
    check("wrap_addr0", req_q[base_i], 24'hFFFFFC);
    check("wrap_addr1", req_q[base_i + 1], 24'h000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_line_fetcher.md
VIDEO_LINE_FETCHER -- requirements
Module: video_line_fetcher

Interface
REQ-001 Parameter WORDS_PER_LINE, default 320, meaning 16-bit words fetched per scanline; SHALL be a multiple of BURST_LEN.
REQ-002 Parameter BURST_LEN, default 4, meaning words per SDRAM burst.
REQ-003 Parameter FIFO_DEPTH, default 16, meaning line FIFO depth in words; SHALL be a power of two and at least 2*BURST_LEN.
REQ-004 clk_i  in  1  sole clock; all logic on its rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 fb_base_x16  in  24  framebuffer base word address, sampled on frame_start_i.
REQ-007 frame_start_i  in  1  one-cycle pulse: restart at fb_base_x16 and flush FIFO.
REQ-008 line_start_i  in  1  one-cycle pulse: begin fetching the next WORDS_PER_LINE words.
REQ-009 pix_rd_i  in  1  consumer pops FIFO head this cycle.
REQ-010 pix_data_o  out  16  FIFO head word (first-word fall-through).
REQ-011 pix_valid_o  out  1  FIFO non-empty.
REQ-012 underflow_o  out  1  sticky: pop attempted while empty.
REQ-013 late_o  out  1  sticky: line_start_i arrived while the previous line was incomplete.
REQ-014 video_sdram_rd  out  1  burst read request to arbiter.
REQ-015 video_sdram_addr_x16  out  24  burst start word address.
REQ-016 video_sdram_rdy  in  1  rdata valid this cycle (one word per assertion).
REQ-017 video_sdram_rdata  in  16  read data.
REQ-018 video_sdram_ack  out  1  one-cycle burst release to arbiter.

Function
REQ-019 FSM states: IDLE, REQ, ACK; reset state IDLE.
REQ-020 IDLE->REQ when words_left>0, FIFO free space >= BURST_LEN, and no frame restart pending; video_sdram_rd=1 in REQ only.
REQ-021 video_sdram_addr_x16 SHALL equal cur_addr and stay stable throughout REQ.
REQ-022 In REQ, each cycle with video_sdram_rdy=1 SHALL push video_sdram_rdata into the FIFO and increment beat_cnt.
REQ-023 On the BURST_LEN-th rdy, REQ->ACK; in ACK, video_sdram_ack=1 and video_sdram_rd=0 for exactly one cycle, then ACK->IDLE; this yields at least one idle cycle between bursts.
REQ-024 On ACK: cur_addr += BURST_LEN, modulo 2^24 (wraps 24'hFFFFFC -> 0 for BURST_LEN=4); words_left -= BURST_LEN.
REQ-025 line_start_i with words_left==0 SHALL load words_left=WORDS_PER_LINE; with words_left!=0 it SHALL be ignored and set late_o.
REQ-026 frame_start_i SHALL set restart_pending; a burst in progress completes normally (no SDRAM abort); in IDLE with restart_pending: flush FIFO, cur_addr=sampled fb_base, words_left=0, clear restart_pending, in one cycle.
REQ-027 frame_start_i SHALL NOT clear sticky flags; only reset clears them.
REQ-028 A word pushed in cycle N SHALL be visible on pix_data_o/pix_valid_o in cycle N+1.
REQ-029 pix_rd_i with pix_valid_o=1 pops; with pix_valid_o=0 it has no FIFO effect and sets underflow_o.
REQ-030 Simultaneous push and pop SHALL be legal in any occupancy, count unchanged; the free-space check in REQ-020 guarantees no overflow.
REQ-031 frame_start_i and line_start_i in the same cycle: frame restart takes effect first, and the line load applies after the flush.

Reset
REQ-032 While rst_i=1: state IDLE, video_sdram_rd=0, video_sdram_ack=0, video_sdram_addr_x16=0, cur_addr=0, words_left=0, FIFO empty, pix_valid_o=0, underflow_o=0, late_o=0, restart_pending=0.
REQ-033 Reset asserted mid-burst SHALL drop video_sdram_rd immediately without ack; system reset SHALL also reset the arbiter.

Structure
REQ-034 Package video_pkg SHALL hold the FSM state enum and the default WORDS_PER_LINE, BURST_LEN and FIFO_DEPTH constants.
REQ-035 The FIFO SHALL be a sub-module sync_fifo (16-bit width, parameterised depth, first-word fall-through, count output).

Verification
REQ-036 fb_base=24'h001000, frame_start, line_start, rdy every cycle after a 2-cycle wait -> 80 bursts at addresses 001000, 001004, ... 00113C; 320 words in order; one ack per burst.
REQ-037 Consumer stalled -> at most FIFO_DEPTH words buffered; no request issued while free space <4; requests resume after 4 pops.
REQ-038 frame_start on the 2nd beat of a burst -> burst finishes with 4 rdy and ack; FIFO then empty; next request at new fb_base.
REQ-039 fb_base=24'hFFFFFC, line of 8 words -> addresses FFFFFC then 000000.
REQ-040 pix_rd_i while empty -> underflow_o=1 and stays set; line_start during an incomplete line -> late_o=1 and words_left unchanged.
REQ-041 rst_i pulsed mid-REQ -> video_sdram_rd=0 asynchronously, all outputs at REQ-032 values.
